// File: rtl/usb_token_crc5_ctrl_pkg.sv
// rtl/usb_token_crc5_ctrl_pkg.sv - shared types and constants for the USB token CRC5 block
//
// Contents:
//   state_t      - controller states IDLE / SHIFT / DONE
//   TOKEN_W      - token field width (7-bit address + 4-bit endpoint)
//   CRC_W        - CRC width
//   CRC5_POLY    - x^5 + x^2 + 1, low terms only
//   CRC5_INIT    - LFSR preset
//   crc5_to_wire - final LFSR state to transmitted CRC (inverted, bit-reversed)
package usb_token_crc5_ctrl_pkg;

    localparam int TOKEN_W = 11;
    localparam int CRC_W   = 5;

    localparam logic [CRC_W-1:0] CRC5_POLY = 5'b00101;
    localparam logic [CRC_W-1:0] CRC5_INIT = 5'h1F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The LFSR MSB is sent first, so wire bit i is the complement of lfsr[4-i].
    function automatic logic [CRC_W-1:0] crc5_to_wire(input logic [CRC_W-1:0] lfsr);
        logic [CRC_W-1:0] w;
        for (int i = 0; i < CRC_W; i++) begin
            w[i] = ~lfsr[CRC_W-1-i];
        end
        return w;
    endfunction

endpackage

// File: rtl/crc5_serial_step.sv
// rtl/crc5_serial_step.sv - combinational single-bit CRC5 LFSR update
//
// Ports:
//   lfsr      in  [4:0] current LFSR state
//   bit_in    in        next token bit (wire order)
//   lfsr_next out [4:0] LFSR state after consuming bit_in
module crc5_serial_step
    import usb_token_crc5_ctrl_pkg::*;
(
    input  logic [CRC_W-1:0] lfsr,
    input  logic             bit_in,
    output logic [CRC_W-1:0] lfsr_next
);

    logic fb;

    assign fb        = bit_in ^ lfsr[CRC_W-1];
    assign lfsr_next = {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? CRC5_POLY : {CRC_W{1'b0}});

endmodule

// File: rtl/usb_token_crc5_ctrl.sv
// rtl/usb_token_crc5_ctrl.sv - bit-serial USB token CRC5 generate/check controller
//
// Ports:
//   clk       in              rising-edge clock
//   reset     in              asynchronous active-high reset
//   start     in              begin an operation (accepted only in IDLE)
//   mode      in              0 = generate, 1 = check (captured with start)
//   token_in  in  [TOKEN_W]   token field, bit 0 first on the wire
//   crc_in    in  [5]         received CRC5, bit 0 first on the wire
//   abort     in              cancel an operation in SHIFT
//   busy      out             high while shifting
//   done      out             one-cycle completion pulse
//   crc_out   out [5]         computed CRC5, wire order, held between operations
//   crc_ok    out             check-mode match flag, held between operations
module usb_token_crc5_ctrl
    import usb_token_crc5_ctrl_pkg::*;
#(
    parameter int               TOKEN_W  = usb_token_crc5_ctrl_pkg::TOKEN_W,
    parameter logic [CRC_W-1:0] CRC_INIT = usb_token_crc5_ctrl_pkg::CRC5_INIT
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [TOKEN_W-1:0] token_in,
    input  logic [CRC_W-1:0]   crc_in,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [CRC_W-1:0]   crc_out,
    output logic               crc_ok
);

    localparam int               CNT_W    = $clog2(TOKEN_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOKEN_W - 1);

    state_t             state;
    state_t             state_nxt;
    logic [TOKEN_W-1:0] tok_sr;
    logic [CRC_W-1:0]   crc_cap;
    logic               mode_q;
    logic [CRC_W-1:0]   lfsr;
    logic [CRC_W-1:0]   lfsr_step;
    logic [CRC_W-1:0]   crc_calc;
    logic [CNT_W-1:0]   bit_cnt;
    logic               last_bit;

    // The captured token is shifted right so the bit being consumed is always tok_sr[0].
    crc5_serial_step u_step (
        .lfsr      (lfsr),
        .bit_in    (tok_sr[0]),
        .lfsr_next (lfsr_step)
    );

    assign crc_calc = crc5_to_wire(lfsr_step);
    assign last_bit = (bit_cnt == LAST_BIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !abort) state_nxt = SHIFT;
            SHIFT: begin
                if (abort)         state_nxt = IDLE;
                else if (last_bit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // Results are written only on the final shift, so an abort or an ignored
    // start leaves crc_out/crc_ok exactly as the last completed operation left them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tok_sr  <= '0;
            crc_cap <= '0;
            mode_q  <= 1'b0;
            lfsr    <= CRC_INIT;
            bit_cnt <= '0;
            crc_out <= '0;
            crc_ok  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        tok_sr  <= token_in;
                        crc_cap <= crc_in;
                        mode_q  <= mode;
                        lfsr    <= CRC_INIT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (!abort) begin
                        lfsr    <= lfsr_step;
                        tok_sr  <= tok_sr >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            crc_out <= crc_calc;
                            crc_ok  <= mode_q && (crc_calc == crc_cap);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_token_crc5_ctrl.sv
// tb/tb_usb_token_crc5_ctrl.sv - self-checking bench for usb_token_crc5_ctrl
module tb_usb_token_crc5_ctrl;

    localparam int TW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mode;
    logic [TW-1:0] token_in;
    logic [4:0]    crc_in;
    logic          abort;
    logic          busy;
    logic          done;
    logic [4:0]    crc_out;
    logic          crc_ok;

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int done_cnt = 0;

    usb_token_crc5_ctrl #(.TOKEN_W(TW), .CRC_INIT(5'h1F)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .token_in (token_in),
        .crc_in   (crc_in),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .crc_out  (crc_out),
        .crc_ok   (crc_ok)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, got still running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: CRC5 over x^5+x^2+1, preset all ones, message LSB first,
    // remainder complemented and sent MSB first.
    function automatic logic [4:0] model_crc5(input logic [TW-1:0] tok);
        int r;
        int top;
        int b;
        logic [4:0] w;
        r = 31;
        for (int i = 0; i < TW; i++) begin
            b   = int'(tok[i]);
            top = (r >> 4) & 1;
            r   = (r << 1) & 31;
            if ((b ^ top) != 0) r = r ^ 5;
        end
        for (int j = 0; j < 5; j++) w[j] = ~r[4-j];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic m, input logic [TW-1:0] t, input logic [4:0] c, output int n);
        n        = cyc;
        start    = 1'b1;
        mode     = m;
        token_in = t;
        crc_in   = c;
        tick();
        start    = 1'b0;
        mode     = 1'($urandom);
        token_in = TW'($urandom);
        crc_in   = 5'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            if (done === 1'b1) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic run_op(input string name, input logic m, input logic [TW-1:0] t,
                          input logic [4:0] c, input logic [4:0] ec, input logic eo);
        int n;
        bit seen;
        issue(m, t, c, n);
        wait_done(40, seen);
        check($sformatf("%s done_seen", name), 32'(seen), 32'd1);
        if (seen) begin
            check($sformatf("%s latency", name), cyc - n, TW + 1);
            check($sformatf("%s crc_out", name), 32'(crc_out), 32'(ec));
            check($sformatf("%s crc_ok", name), 32'(crc_ok), 32'(eo));
            tick();
            check($sformatf("%s done_width", name), 32'(done), 32'd0);
        end
    endtask

    typedef struct {
        logic          m;
        logic [TW-1:0] t;
        logic [4:0]    c;
        logic [4:0]    ec;
        logic          eo;
    } vec_t;

    vec_t          vecs[7];
    int            n;
    int            d0;
    bit            seen;
    logic [TW-1:0] t1;
    logic [TW-1:0] rt;
    logic [4:0]    re;
    logic [4:0]    bad;

    initial begin
        vecs[0] = '{1'b0, 11'h000, 5'h00, 5'h02, 1'b0};
        vecs[1] = '{1'b1, 11'h000, 5'h02, 5'h02, 1'b1};
        vecs[2] = '{1'b1, 11'h000, 5'h03, 5'h02, 1'b0};
        vecs[3] = '{1'b0, 11'h7FF, 5'h00, 5'h08, 1'b0};
        vecs[4] = '{1'b1, 11'h7FF, 5'h08, 5'h08, 1'b1};
        vecs[5] = '{1'b1, 11'h7FF, 5'h09, 5'h08, 1'b0};
        vecs[6] = '{1'b0, 11'h000, 5'h02, 5'h02, 1'b0};

        reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
        token_in = '0; crc_in = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset crc_out", 32'(crc_out), 32'd0);
        check("reset crc_ok", 32'(crc_ok), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].t, vecs[i].c, vecs[i].ec, vecs[i].eo);
        end

        // start pulsed again at N+5 is ignored
        t1 = 11'h2A5;
        issue(1'b1, t1, model_crc5(t1), n);
        while (cyc < n + 5) tick();
        start = 1'b1; mode = 1'b0; token_in = 11'h7FF; crc_in = 5'h00;
        d0 = done_cnt;
        tick();
        start = 1'b0;
        wait_done(20, seen);
        check("restart done_seen", 32'(seen), 32'd1);
        check("restart latency", cyc - n, TW + 1);
        check("restart crc_out", 32'(crc_out), 32'(model_crc5(t1)));
        check("restart crc_ok", 32'(crc_ok), 32'd1);
        repeat (16) tick();
        check("restart done_count", done_cnt - d0, 1);

        // abort at N+6
        issue(1'b0, 11'h155, 5'h00, n);
        while (cyc < n + 6) tick();
        abort = 1'b1;
        d0 = done_cnt;
        tick();
        abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        repeat (15) tick();
        check("abort no_done", done_cnt - d0, 0);
        check("abort crc_out", 32'(crc_out), 32'(model_crc5(t1)));
        check("abort crc_ok", 32'(crc_ok), 32'd1);
        run_op("after_abort", 1'b0, 11'h155, 5'h00, model_crc5(11'h155), 1'b0);

        // abort and start together in IDLE
        start = 1'b1; abort = 1'b1; mode = 1'b1; token_in = 11'h003; crc_in = 5'h00;
        d0 = done_cnt;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start busy", 32'(busy), 32'd0);
        repeat (14) tick();
        check("abort_start no_done", done_cnt - d0, 0);
        check("abort_start crc_out", 32'(crc_out), 32'(model_crc5(11'h155)));

        // abort during DONE leaves the pulse and result intact
        issue(1'b1, 11'h0F0, model_crc5(11'h0F0), n);
        wait_done(40, seen);
        check("abort_done seen", 32'(seen), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done pulse_end", 32'(done), 32'd0);
        check("abort_done crc_ok", 32'(crc_ok), 32'd1);

        // start held from DONE into the following IDLE: accepted one cycle later
        issue(1'b0, 11'h321, 5'h00, n);
        while (cyc < n + 12) tick();
        check("b2b first_done", 32'(done), 32'd1);
        start = 1'b1; mode = 1'b0; token_in = 11'h4B2; crc_in = 5'h00;
        tick();
        tick();
        start = 1'b0;
        wait_done(30, seen);
        check("b2b second_seen", 32'(seen), 32'd1);
        check("b2b interval", cyc - n, 2 * TW + 3);
        check("b2b crc_out", 32'(crc_out), 32'(model_crc5(11'h4B2)));
        tick();

        // asynchronous reset in the middle of SHIFT
        issue(1'b1, 11'h6C3, model_crc5(11'h6C3), n);
        while (cyc < n + 4) tick();
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid done", 32'(done), 32'd0);
        check("rst_mid crc_out", 32'(crc_out), 32'd0);
        check("rst_mid crc_ok", 32'(crc_ok), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("after_reset", 1'b0, 11'h6C3, 5'h00, model_crc5(11'h6C3), 1'b0);
        check("rst_mid done_count", done_cnt - d0, 1);

        // random regression: generate then check each token
        for (int i = 0; i < 1000; i++) begin
            rt = TW'($urandom);
            re = model_crc5(rt);
            run_op("rand_gen", 1'b0, rt, 5'($urandom), re, 1'b0);
            run_op("rand_chk", 1'b1, rt, re, re, 1'b1);
            if (i % 8 == 0) begin
                bad = re ^ 5'($urandom_range(1, 31));
                run_op("rand_bad", 1'b1, rt, bad, re, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
